// File: rtl/adler32_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : adler32_stream_gen
// Brief    : Multi-byte streaming Adler-32 generator with seed chaining.
// Revision : 1.0 - initial release
// ============================================================================
module adler32_stream_gen #(
   parameter int BYTES_PER_BEAT = 4,
   parameter int SIZE_W         = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SIZE_W-1:0]           size,
   input  logic                        size_valid,
   input  logic [31:0]                 seed,
   input  logic                        data_start,
   input  logic                        data_valid,
   input  logic [8*BYTES_PER_BEAT-1:0] data,
   output logic                        ready,
   output logic                        busy,
   output logic [31:0]                 checksum,
   output logic                        valid,
   output logic                        err
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_ARMED = 2'd1;
   localparam logic [1:0]  S_RUN   = 2'd2;
   localparam logic [1:0]  S_DONE  = 2'd3;
   localparam logic [16:0] c_MOD   = 17'd65521;
   localparam logic [15:0] c_MOD16 = 16'd65521;
   localparam logic [SIZE_W-1:0] c_BPB = SIZE_W'(BYTES_PER_BEAT);

   logic [1:0]        state_q, state_d;
   logic [SIZE_W-1:0] remaining_q, remaining_d;
   logic [15:0]       a_q, a_d, b_q, b_d;
   logic [31:0]       checksum_q, checksum_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic [15:0]       w_acc_a, w_acc_b;
   logic [16:0]       w_sum_a, w_sum_b;
   logic [15:0]       w_seed_a, w_seed_b;
   logic [SIZE_W-1:0] w_take;
   logic              w_last;

   // Lanes beyond the remaining byte count leave A/B untouched.
   always_comb begin
      w_acc_a = a_q;
      w_acc_b = b_q;
      w_sum_a = 17'd0;
      w_sum_b = 17'd0;
      for (int i = 0; i < BYTES_PER_BEAT; i++) begin
         if (remaining_q > SIZE_W'(i)) begin
            w_sum_a = {1'b0, w_acc_a} + {9'd0, data[8*i +: 8]};
            w_acc_a = (w_sum_a >= c_MOD) ? 16'(w_sum_a - c_MOD) : w_sum_a[15:0];
            w_sum_b = {1'b0, w_acc_b} + {1'b0, w_acc_a};
            w_acc_b = (w_sum_b >= c_MOD) ? 16'(w_sum_b - c_MOD) : w_sum_b[15:0];
         end
      end
   end

   assign w_take   = (remaining_q >= c_BPB) ? c_BPB : remaining_q;
   assign w_last   = (remaining_q <= c_BPB);
   assign w_seed_a = (seed[15:0]  >= c_MOD16) ? seed[15:0]  - c_MOD16 : seed[15:0];
   assign w_seed_b = (seed[31:16] >= c_MOD16) ? seed[31:16] - c_MOD16 : seed[31:16];

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      a_d         = a_q;
      b_d         = b_q;
      checksum_d  = checksum_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (size_valid) begin
               remaining_d = size;
               a_d         = w_seed_a;
               b_d         = w_seed_b;
               err_d       = 1'b0;
               state_d     = (size == '0) ? S_DONE : S_ARMED;
            end
         end
         S_ARMED: begin
            // A recapture wins over a coincident start beat.
            if (size_valid) begin
               remaining_d = size;
               a_d         = w_seed_a;
               b_d         = w_seed_b;
               state_d     = (size == '0) ? S_DONE : S_ARMED;
            end else if (data_start && data_valid) begin
               a_d         = w_acc_a;
               b_d         = w_acc_b;
               remaining_d = remaining_q - w_take;
               state_d     = w_last ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (size_valid || data_start) begin
               err_d = 1'b1;
            end
            if (data_valid) begin
               a_d         = w_acc_a;
               b_d         = w_acc_b;
               remaining_d = remaining_q - w_take;
               state_d     = w_last ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            if (size_valid) begin
               err_d = 1'b1;
            end
            checksum_d = {b_q, a_q};
            valid_d    = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         a_q         <= '0;
         b_q         <= '0;
         checksum_q  <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         a_q         <= a_d;
         b_q         <= b_d;
         checksum_q  <= checksum_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign ready    = (state_q == S_ARMED) || (state_q == S_RUN);
   assign busy     = (state_q != S_IDLE);
   assign checksum = checksum_q;
   assign valid    = valid_q;
   assign err      = err_q;

endmodule
`default_nettype wire
